interrupt_dispatch_ctrl: RTL
============================

// Module: interrupt_dispatch_ctrl
// PURPOSE
//  Per-core controller between the event unit's masked interrupt buffer and the core's IRQ port.
//  Selects one pending line (fixed or round-robin priority), presents its id to the core with a
//  req/ack handshake, pulses that line's buffer-clear bit on ack, and flags stalled requests.
// PARAMETERS
//  NUM_IRQ   32    number of interrupt lines (width of pending vector and clear vector)
//  ID_W      5     id width; $clog2(NUM_IRQ)
//  RR_EN     0     0: fixed priority, lowest index wins; 1: round-robin, search starts after last acked id
//  TMO_CYC   256   cycles irq_req_o may stay high un-acked before timeout (>=2)
// PORTS
//  clk_i          in   1        clock
//  rst_i          in   1        reset, synchronous, active-high
//  en_i           in   1        dispatch enable; 0 blocks new dispatch only
//  pending_i      in   NUM_IRQ  masked interrupt buffer status (buffer & mask)
//  irq_req_o      out  1        interrupt request to core
//  irq_id_o       out  ID_W     id of requested line; stable while irq_req_o=1
//  irq_ack_i      in   1        core accepts irq_id_o; valid only while irq_req_o=1
//  buf_clear_o    out  NUM_IRQ  one-hot clear pulse to interrupt buffer
//  timeout_o      out  1        1-cycle pulse: request withdrawn after TMO_CYC cycles
//  busy_o         out  1        1 when FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE; irq_req_o=0, irq_id_o=0, buf_clear_o=0, timeout_o=0, busy_o=0;
//   RR pointer=NUM_IRQ-1 (first RR search starts at 0); timeout counter=0. Reset wins over all.
//  FSM states IDLE, REQ, CLR:
//   IDLE: if en_i && |pending_i -> latch selected id into irq_id_o, go REQ (req high next cycle).
//   REQ : irq_req_o=1; counter increments each cycle.
//    - irq_ack_i=1                  -> CLR (ack takes priority over withdraw and timeout).
//    - else pending_i[id]=0         -> IDLE, no clear, no timeout (line masked/cleared by SW).
//    - else counter==TMO_CYC-1      -> IDLE, timeout_o=1 for one cycle, no clear.
//   CLR : buf_clear_o[id]=1 exactly one cycle, irq_req_o=0; RR pointer<=id; -> IDLE.
//  Buffer updates at the edge ending CLR, so the following IDLE cycle already sees the cleared
//   bit: no double dispatch of the same event. A new edge on that line is dispatched normally.
//  Latency: pending rising in cycle N (IDLE, en_i=1) -> irq_req_o=1 in cycle N+1.
//   ack in cycle M -> buf_clear_o in M+1 -> earliest next irq_req_o in M+3.
//  Selection: fixed = lowest set index; RR = first set index in (ptr+1 .. ptr) modulo NUM_IRQ.
//   Selection is sampled only in IDLE; pending changes during REQ do not change irq_id_o.
//  en_i=0 during REQ/CLR does not abort the transaction.
//  Counter cleared on entry to REQ; width $clog2(TMO_CYC+1); never wraps.
//  irq_ack_i while not in REQ is ignored. buf_clear_o is zero outside CLR, always <=1 bit set.
//  busy_o=1 in REQ and CLR.
// TESTING
//  1 Reset: assert rst_i with pending_i=32'hFFFF_FFFF -> all outputs 0 while held, REQ one cycle after release.
//  2 Fixed prio: RR_EN=0, pending=32'h0000_0090 -> irq_id_o=4; ack -> buf_clear_o=32'h10 for 1 cycle, then id=7.
//  3 Round-robin: RR_EN=1, pending held 32'h0000_0009 with bits re-set after each clear -> ids 0,3,0,3.
//  4 Withdraw: REQ id=2, drop pending[2] before ack -> irq_req_o falls next cycle, buf_clear_o stays 0, timeout_o=0.
//  5 Timeout: TMO_CYC=4, no ack -> irq_req_o high exactly 4 cycles, timeout_o pulse, no clear; re-request next IDLE.
//  6 Ack on timeout cycle and en_i=0 mid-REQ -> ack wins (clear issued, no timeout); no new REQ while en_i=0.

Source files
------------

// File: rtl/interrupt_dispatch_ctrl.sv
// Per-core interrupt dispatcher: picks one pending line, runs a req/ack handshake with the core,
// pulses the buffer-clear bit of the acked line and withdraws stalled requests after TMO_CYC cycles.
module interrupt_dispatch_ctrl #(
    parameter int unsigned NUM_IRQ = 32,
    parameter int unsigned ID_W    = $clog2(NUM_IRQ),
    parameter int unsigned RR_EN   = 0,
    parameter int unsigned TMO_CYC = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [NUM_IRQ-1:0] pending_i,
    output logic               irq_req_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i,
    output logic [NUM_IRQ-1:0] buf_clear_o,
    output logic               timeout_o,
    output logic               busy_o
);

    localparam int unsigned     CNT_W    = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_IRQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CLR  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic [NUM_IRQ-1:0]   clr_q, clr_d;
    logic                 tmo_q, tmo_d;
    logic                 busy_q, busy_d;

    logic [ID_W-1:0]      search_base;
    logic [ID_W-1:0]      sel_id;
    logic                 sel_found;

    // Index 'off+1' positions after base, wrapping at NUM_IRQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned j;
        j = 32'(base) + off + 32'd1;
        if (j >= NUM_IRQ) begin
            j = j - NUM_IRQ;
        end
        return ID_W'(j);
    endfunction

    // Fixed priority is a search that always starts at index 0.
    assign search_base = (RR_EN != 0) ? ptr_q : ID_LAST;

    always_comb begin : sel_proc
        sel_id    = '0;
        sel_found = 1'b0;
        for (int unsigned off = 0; off < NUM_IRQ; off++) begin
            if (!sel_found && pending_i[wrap_idx(search_base, off)]) begin
                sel_found = 1'b1;
                sel_id    = wrap_idx(search_base, off);
            end
        end
    end

    always_comb begin : next_proc
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        clr_d   = '0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && sel_found) begin
                    state_d = REQ;
                    id_d    = sel_id;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                // Ack beats both withdraw and timeout.
                if (irq_ack_i) begin
                    state_d = CLR;
                    clr_d   = NUM_IRQ'(1) << id_q;
                end else if (!pending_i[id_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLR: begin
                state_d = IDLE;
                ptr_d   = id_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin : state_reg
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= ID_LAST;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            clr_q   <= '0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            clr_q   <= clr_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
        end
    end

    assign irq_req_o   = req_q;
    assign irq_id_o    = id_q;
    assign buf_clear_o = clr_q;
    assign timeout_o   = tmo_q;
    assign busy_o      = busy_q;

endmodule
